// File: rtl/mbscore_mem_arb_pkg.sv
// Shared core constants for the memory arbiter: bus width, starvation limit, FSM encoding.
// Also holds the fetch/data arbitration decision so the policy lives in one place.
package mbscore_mem_arb_pkg;

   localparam int MBSCORE_DATA_WIDTH   = 32;
   localparam int MBSCORE_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IF_ACC = 2'd1,
      ST_D_ACC  = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   // Data normally wins; fetch wins only when unopposed or when it has been starved.
   function automatic logic fetch_wins(input logic if_ok, input logic d_req, input logic force_if);
      return if_ok && (!d_req || force_if);
   endfunction

endpackage

// File: rtl/mbscore_arb_starve_cnt.sv
// Counts data grants made while a fetch waits; force_if flags that fetch must win next.
// One cycle from grant to updated count; STARVE_LIMIT must be at least 1.
module mbscore_arb_starve_cnt
   import mbscore_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = MBSCORE_STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic grant_d,
   input  logic grant_if,
   input  logic if_pending,
   output logic force_if
);

   localparam int              CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_if || !if_pending) begin
         cnt_d = '0;
      end else if (grant_d && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/mbscore_mem_arb.sv
// Single-port memory arbiter between instruction fetch and data access, one access in flight.
// Strobe 1 cycle after grant, ack 1 cycle after mem_ready; requesters stall by holding their request.
module mbscore_mem_arb
   import mbscore_mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = MBSCORE_DATA_WIDTH,
   parameter int STARVE_LIMIT = MBSCORE_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_re,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  hlt,
   input  logic                  d_re,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   arb_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;
   logic                  if_ack_q, if_ack_d;
   logic                  d_ack_q, d_ack_d;

   logic grant_if;
   logic grant_d;
   logic force_if;
   logic d_req;
   logic if_ok;

   assign d_req = d_re | d_we;
   assign if_ok = if_re & ~hlt;

   mbscore_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .grant_d    (grant_d),
      .grant_if   (grant_if),
      .if_pending (if_re),
      .force_if   (force_if)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      mem_re_d   = mem_re_q;
      mem_we_d   = mem_we_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      grant_if   = 1'b0;
      grant_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fetch_wins(if_ok, d_req, force_if)) begin
               grant_if = 1'b1;
               state_d  = ST_IF_ACC;
               addr_d   = if_addr;
               wdata_d  = '0;
               mem_re_d = 1'b1;
               mem_we_d = 1'b0;
            end else if (d_req) begin
               // A simultaneous read and write request is executed as a write.
               grant_d  = 1'b1;
               state_d  = ST_D_ACC;
               addr_d   = d_addr;
               wdata_d  = d_we ? d_wdata : '0;
               mem_re_d = ~d_we;
               mem_we_d = d_we;
            end
         end

         ST_IF_ACC: begin
            if (mem_ready) begin
               if_rdata_d = mem_rdata;
               mem_re_d   = 1'b0;
               mem_we_d   = 1'b0;
               if_ack_d   = 1'b1;
               state_d    = ST_RESP;
            end
         end

         ST_D_ACC: begin
            if (mem_ready) begin
               d_rdata_d = mem_rdata;
               mem_re_d  = 1'b0;
               mem_we_d  = 1'b0;
               d_ack_d   = 1'b1;
               state_d   = ST_RESP;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         mem_re_q   <= mem_re_d;
         mem_we_q   <= mem_we_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mbscore_mem_arb.sv
// Bench for mbscore_mem_arb: behavioural memory with programmable latency plus an ack scoreboard.
module tb_mbscore_mem_arb;

   localparam int DW = 32;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_re, hlt, d_re, d_we;
   logic [DW-1:0] if_addr, d_addr, d_wdata;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          if_ack, d_ack;
   logic          mem_re, mem_we, mem_ready;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mbscore_mem_arb #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_re(if_re), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .hlt(hlt),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic          is_if;
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
   } exp_t;

   exp_t sbq[$];

   int tests_run    = 0;
   int tests_failed = 0;
   int mem_lat      = 2;
   bit spur         = 1'b0;

   int            re_cycles = 0, we_cycles = 0, re_rises = 0;
   logic          prev_re = 1'b0;
   logic [DW-1:0] cap_addr = '0, cap_wdata = '0;
   logic          cap_we = 1'b0;
   int            scnt = 0;

   function automatic logic [DW-1:0] mem_fn(input logic [DW-1:0] a);
      return 32'h1022_0001 ^ {a[27:0], 4'h0};
   endfunction

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic is_if, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd);
      exp_t e;
      e.is_if = is_if; e.we = we; e.addr = a; e.wdata = wd;
      sbq.push_back(e);
   endtask

   // Memory model, strobe monitor and ack scoreboard, all evaluated at the falling edge.
   initial begin
      exp_t e;
      logic [DW-1:0] got;
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         if (mem_re && !prev_re) re_rises++;
         prev_re = mem_re;
         if (mem_re) re_cycles++;
         if (mem_we) we_cycles++;
         if (mem_re || mem_we) begin
            tests_run++;
            if (mem_re && mem_we) begin
               tests_failed++;
               $display("FAIL strobe_excl: mem_re=%b mem_we=%b, required at most one high", mem_re, mem_we);
            end
         end

         if (!rst_n) begin
            scnt = 0; mem_ready = 1'b0;
         end else if (spur) begin
            mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
         end else if (mem_re || mem_we) begin
            scnt++;
            if (scnt == 1) begin
               cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
            end else begin
               tests_run++;
               if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
                  tests_failed++;
                  $display("FAIL mem_stable: addr=%h wdata=%h we=%b, required addr=%h wdata=%h we=%b",
                           mem_addr, mem_wdata, mem_we, cap_addr, cap_wdata, cap_we);
               end
            end
            mem_ready = (scnt == mem_lat);
            mem_rdata = mem_ready ? mem_fn(mem_addr) : 32'hBAD0_BAD0;
         end else begin
            scnt = 0; mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
         end

         if (if_ack || d_ack) begin
            tests_run++;
            if (if_ack && d_ack) begin
               tests_failed++;
               $display("FAIL ack_excl: if_ack=1 d_ack=1, required exactly one");
            end else if (sbq.size() == 0) begin
               tests_failed++;
               $display("FAIL ack_unexpected: if_ack=%b d_ack=%b, required no ack", if_ack, d_ack);
            end else begin
               e   = sbq.pop_front();
               got = if_ack ? if_rdata : d_rdata;
               if (e.is_if !== if_ack) begin
                  tests_failed++;
                  $display("FAIL ack_order: if_ack=%b, required is_if=%b (addr %h)", if_ack, e.is_if, e.addr);
               end else if (cap_addr !== e.addr || cap_we !== e.we) begin
                  tests_failed++;
                  $display("FAIL ack_addr: addr=%h we=%b, required addr=%h we=%b", cap_addr, cap_we, e.addr, e.we);
               end else if (e.we && cap_wdata !== e.wdata) begin
                  tests_failed++;
                  $display("FAIL ack_wdata: wdata=%h, required %h", cap_wdata, e.wdata);
               end else if (!e.we && got !== mem_fn(e.addr)) begin
                  tests_failed++;
                  $display("FAIL ack_rdata: rdata=%h, required %h", got, mem_fn(e.addr));
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; if_re = 1'b0; hlt = 1'b0; d_re = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) sample();
      tests_run++;
      if ({mem_re, mem_we, if_ack, d_ack} !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: re/we/if_ack/d_ack=%b, required 0000", {mem_re, mem_we, if_ack, d_ack});
      end
      tests_run++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         tests_failed++;
         $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
      end
      tests_run++;
      if (if_rdata !== '0 || d_rdata !== '0) begin
         tests_failed++;
         $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, required 0", if_rdata, d_rdata);
      end
      rst_n = 1'b1;
      sample();
   endtask

   task automatic test_fetch();
      mem_lat = 2; if_addr = 32'h0; if_re = 1'b1;
      push(1'b1, 1'b0, 32'h0, '0);
      sample();
      tests_run++;
      if (mem_re !== 1'b1 || mem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL fetch_strobe: mem_re=%b addr=%h, required 1 / 0", mem_re, mem_addr);
      end
      sample();
      tests_run++;
      if (mem_re !== 1'b1 || if_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch_wait: mem_re=%b if_ack=%b, required 1 / 0", mem_re, if_ack);
      end
      sample();
      tests_run++;
      if (if_ack !== 1'b1 || mem_re !== 1'b0 || if_rdata !== 32'h1022_0001) begin
         tests_failed++;
         $display("FAIL fetch_ack: if_ack=%b mem_re=%b if_rdata=%h, required 1 / 0 / 10220001",
                  if_ack, mem_re, if_rdata);
      end
      if_re = 1'b0;
      sample();
      tests_run++;
      if (if_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch_pulse: if_ack=%b, required 0", if_ack);
      end
   endtask

   task automatic test_priority();
      int base, d_at, i_at;
      base = re_rises; d_at = -1; i_at = -1;
      mem_lat = 2; if_addr = 32'h8; d_addr = 32'h100; if_re = 1'b1; d_re = 1'b1;
      push(1'b0, 1'b0, 32'h100, '0);
      push(1'b1, 1'b0, 32'h8, '0);
      for (int t = 0; t < 60 && (d_at < 0 || i_at < 0); t++) begin
         sample();
         if (d_ack) begin d_at = t; d_re = 1'b0; end
         if (if_ack) begin i_at = t; if_re = 1'b0; end
      end
      d_re = 1'b0; if_re = 1'b0;
      tests_run++;
      if (d_at != 2 || i_at != 6) begin
         tests_failed++;
         $display("FAIL prio_timing: d_ack@%0d if_ack@%0d, required 2 / 6", d_at, i_at);
      end
      tests_run++;
      if (re_rises - base != 2) begin
         tests_failed++;
         $display("FAIL prio_rises: mem_re rising edges=%0d, required 2", re_rises - base);
      end
   endtask

   task automatic test_starve();
      int dcnt, icnt, d_before_if;
      dcnt = 0; icnt = 0; d_before_if = -1;
      mem_lat = 2; d_addr = 32'h200; if_addr = 32'h30; d_re = 1'b1; if_re = 1'b1;
      repeat (SL) push(1'b0, 1'b0, 32'h200, '0);
      push(1'b1, 1'b0, 32'h30, '0);
      push(1'b0, 1'b0, 32'h200, '0);
      for (int t = 0; t < 200 && !(dcnt == SL + 1 && icnt == 1); t++) begin
         sample();
         if (d_ack) begin
            dcnt++;
            if (dcnt == SL + 1) d_re = 1'b0;
         end
         if (if_ack) begin icnt++; d_before_if = dcnt; if_re = 1'b0; end
      end
      d_re = 1'b0; if_re = 1'b0;
      tests_run++;
      if (d_before_if != SL) begin
         tests_failed++;
         $display("FAIL starve_force: data acks before fetch=%0d, required %0d", d_before_if, SL);
      end
      tests_run++;
      if (dcnt != SL + 1 || icnt != 1) begin
         tests_failed++;
         $display("FAIL starve_total: d_acks=%0d if_acks=%0d, required %0d / 1", dcnt, icnt, SL + 1);
      end
   endtask

   task automatic test_write();
      int bw, br, acks;
      // Plain write with a three-cycle strobe.
      bw = we_cycles; br = re_cycles; acks = 0;
      mem_lat = 3; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      push(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
      for (int t = 0; t < 30; t++) begin
         sample();
         if (d_ack) begin acks++; d_we = 1'b0; end
      end
      tests_run++;
      if (we_cycles - bw != 3 || re_cycles - br != 0 || acks != 1) begin
         tests_failed++;
         $display("FAIL write_strobe: we_cycles=%0d re_cycles=%0d acks=%0d, required 3 / 0 / 1",
                  we_cycles - bw, re_cycles - br, acks);
      end
      // Read and write together resolve to a write.
      bw = we_cycles; br = re_cycles; acks = 0;
      mem_lat = 2; d_we = 1'b1; d_re = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
      push(1'b0, 1'b1, 32'h44, 32'h1234_5678);
      for (int t = 0; t < 20; t++) begin
         sample();
         if (d_ack) begin acks++; d_we = 1'b0; d_re = 1'b0; end
      end
      tests_run++;
      if (we_cycles - bw != 2 || re_cycles - br != 0 || acks != 1) begin
         tests_failed++;
         $display("FAIL rw_is_write: we_cycles=%0d re_cycles=%0d acks=%0d, required 2 / 0 / 1",
                  we_cycles - bw, re_cycles - br, acks);
      end
   endtask

   task automatic test_spurious();
      int base, acks;
      base = re_rises; acks = 0;
      spur = 1'b1;
      for (int t = 0; t < 3; t++) begin
         sample();
         if (if_ack || d_ack) acks++;
      end
      spur = 1'b0;
      for (int t = 0; t < 2; t++) begin
         sample();
         if (if_ack || d_ack) acks++;
      end
      tests_run++;
      if (if_rdata !== mem_fn(32'h30) || d_rdata !== mem_fn(32'h44)) begin
         tests_failed++;
         $display("FAIL spur_hold: if_rdata=%h d_rdata=%h, required %h / %h",
                  if_rdata, d_rdata, mem_fn(32'h30), mem_fn(32'h44));
      end
      tests_run++;
      if (acks != 0 || re_rises != base) begin
         tests_failed++;
         $display("FAIL spur_idle: acks=%0d new strobes=%0d, required 0 / 0", acks, re_rises - base);
      end
   endtask

   task automatic test_halt();
      int base;
      bit seen;
      base = re_rises; seen = 1'b0;
      mem_lat = 2; hlt = 1'b1; if_addr = 32'h44; if_re = 1'b1;
      repeat (10) sample();
      tests_run++;
      if (re_rises != base || mem_re !== 1'b0) begin
         tests_failed++;
         $display("FAIL halt_block: strobes=%0d mem_re=%b, required 0 / 0", re_rises - base, mem_re);
      end
      push(1'b1, 1'b0, 32'h44, '0);
      hlt = 1'b0;
      sample();
      tests_run++;
      if (mem_re !== 1'b1 || mem_addr !== 32'h44) begin
         tests_failed++;
         $display("FAIL halt_release: mem_re=%b addr=%h, required 1 / 00000044", mem_re, mem_addr);
      end
      hlt = 1'b1;
      for (int t = 0; t < 20 && !seen; t++) begin
         sample();
         if (if_ack) begin seen = 1'b1; if_re = 1'b0; end
      end
      hlt = 1'b0; if_re = 1'b0;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL halt_inflight: if_ack seen=%b, required 1", seen);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 1'b0;
      mem_lat = 8; d_re = 1'b1; d_addr = 32'h80; if_re = 1'b1; if_addr = 32'h90;
      for (int t = 0; t < 10 && !seen; t++) begin
         sample();
         if (mem_re) seen = 1'b1;
      end
      tests_run++;
      if (!seen || mem_addr !== 32'h80) begin
         tests_failed++;
         $display("FAIL rstmid_data: strobe=%b addr=%h, required 1 / 00000080", seen, mem_addr);
      end
      rst_n = 1'b0;
      sample();
      tests_run++;
      if ({mem_re, mem_we, if_ack, d_ack} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          if_rdata !== '0 || d_rdata !== '0) begin
         tests_failed++;
         $display("FAIL rstmid_zero: ctrl=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
                  {mem_re, mem_we, if_ack, d_ack}, mem_addr, mem_wdata, if_rdata, d_rdata);
      end
      d_re = 1'b0; rst_n = 1'b1; mem_lat = 2;
      push(1'b1, 1'b0, 32'h90, '0);
      sample();
      tests_run++;
      if (mem_re !== 1'b1 || mem_addr !== 32'h90) begin
         tests_failed++;
         $display("FAIL rstmid_fetch: mem_re=%b addr=%h, required 1 / 00000090", mem_re, mem_addr);
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         sample();
         if (if_ack) begin seen = 1'b1; if_re = 1'b0; end
      end
      if_re = 1'b0;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL rstmid_ack: if_ack seen=%b, required 1", seen);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_write();
      test_spurious();
      test_halt();
      test_reset_mid();
      repeat (3) sample();
      tests_run++;
      if (sbq.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain: %0d expected completions outstanding, required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mbscore_mem_arb.md
MBSCORE_MEM_ARB -- requirements
Module: mbscore_mem_arb

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, width of data and address buses; STARVE_LIMIT, default 4, consecutive data grants before fetch is forced.
REQ-002 SHALL have ports, one clock, reset synchronous and active-low:
  clk        in   1           rising-edge clock
  rst_n      in   1           synchronous active-low reset
  if_re      in   1           fetch read request, held until if_ack
  if_addr    in   DATA_WIDTH  fetch address (PC)
  if_rdata   out  DATA_WIDTH  fetched instruction, valid with if_ack
  if_ack     out  1           one-cycle fetch completion pulse
  hlt        in   1           core halted; blocks new fetch grants
  d_re       in   1           data read request, held until d_ack
  d_we       in   1           data write request, held until d_ack
  d_addr     in   DATA_WIDTH  data address
  d_wdata    in   DATA_WIDTH  store data
  d_rdata    out  DATA_WIDTH  load data, valid with d_ack
  d_ack      out  1           one-cycle data completion pulse
  mem_re     out  1           memory read strobe
  mem_we     out  1           memory write strobe
  mem_addr   out  DATA_WIDTH  memory address
  mem_wdata  out  DATA_WIDTH  memory write data
  mem_rdata  in   DATA_WIDTH  memory read data, valid with mem_ready
  mem_ready  in   1           memory completion, any latency >= 1 cycle

Function
REQ-003 SHALL implement FSM IDLE, IF_ACC, D_ACC, RESP; one memory access in flight at a time.
REQ-004 IDLE: on a cycle with a pending request, SHALL latch the winner's address/data/direction and move to IF_ACC or D_ACC next cycle; no request -> stay IDLE.
REQ-005 Arbitration SHALL give data priority over fetch, except when starve count == STARVE_LIMIT and if_re is pending (and hlt low), then fetch wins.
REQ-006 Starve count SHALL increment (saturating at STARVE_LIMIT) per data grant made while if_re is pending, and clear on every fetch grant or when if_re is low.
REQ-007 While hlt is high SHALL grant no new fetch; an in-flight fetch completes normally.
REQ-008 d_we and d_re both high SHALL be treated as a write.
REQ-009 IF_ACC/D_ACC SHALL drive mem_re (or mem_we) high with stable registered mem_addr/mem_wdata every cycle until mem_ready is sampled high.
REQ-010 On mem_ready SHALL register mem_rdata into if_rdata or d_rdata, drop strobes, and enter RESP.
REQ-011 RESP SHALL pulse exactly one of if_ack/d_ack for one cycle, keep both strobes low, then return to IDLE; mem_re therefore has a rising edge per access.
REQ-012 Latency: request first seen in IDLE at cycle N -> strobe high at N+1; mem_ready at cycle M -> ack at M+1; minimum 3 cycles request-to-ack.
REQ-013 Request withdrawn mid-access SHALL not abort; access completes and ack is still pulsed.
REQ-014 if_rdata/d_rdata SHALL hold last value until next completion of the same requester; mem_ready outside IF_ACC/D_ACC SHALL be ignored.

Reset
REQ-015 rst_n low at a clock edge SHALL force IDLE, clear starve count, drive all outputs to 0, aborting any in-flight access without ack.
REQ-016 First grant after reset release SHALL be evaluated in the first cycle rst_n is high.

Structure
REQ-017 DATA_WIDTH default and FSM state encodings SHALL live in the shared core constants header.
REQ-018 Starvation counter SHALL be a sub-module mbscore_arb_starve_cnt (inputs: grant_d, grant_if, if_pending; output: force_if).

Verification
REQ-019 Fetch only: if_re=1, if_addr=0x0, mem_ready 1 cycle after strobe, mem_rdata=0x10220001 -> mem_re high 1 cycle after request, if_ack pulse 1 cycle after mem_ready, if_rdata=0x10220001.
REQ-020 Simultaneous if_re (addr 0x8) and d_re (addr 0x100) -> data served first, d_ack first, then fetch of 0x8 with if_ack; mem_re low for >= 1 cycle between.
REQ-021 d_re held continuously with if_re pending, STARVE_LIMIT=4 -> 4 data acks, then one if_ack before 5th data access.
REQ-022 d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 cycles -> mem_we high 3 cycles with stable addr/data, d_ack once, mem_re never high.
REQ-023 hlt=1 with if_re=1 -> no mem_re for 10 cycles; hlt dropped -> fetch granted next IDLE cycle.
REQ-024 rst_n low during D_ACC -> next edge all outputs 0, no d_ack, state IDLE; pending if_re after release served normally.
